// File: rtl/cbus_master_arb.sv
// Round-robin arbiter sharing one cbus slave port between NUM_REQ cbus masters.
// Optional ISSUE timeout/abort is enabled by defining CBUS_ARB_TIMEOUT_EN.
module cbus_master_arb #(
  parameter int unsigned     NUM_REQ    = 4,
  parameter int unsigned     REQ_WIDTH  = $clog2(NUM_REQ),
  parameter int unsigned     AW         = 16,
  parameter int unsigned     DW         = 32,
  parameter int unsigned     TO_WID     = 8,
  parameter logic [DW-1:0]   ABORT_DATA = 32'hDEAD_BEEF
) (
  input  logic                   clk,
  input  logic                   sreset,
  input  logic [NUM_REQ-1:0]     req_cfg_req,
  input  logic [NUM_REQ-1:0]     req_cmd,
  input  logic [AW*NUM_REQ-1:0]  req_address,
  input  logic [DW*NUM_REQ-1:0]  req_wdata,
  output logic [NUM_REQ-1:0]     req_waccept,
  output logic [NUM_REQ-1:0]     req_rresp,
  output logic [DW-1:0]          req_rdatap,
  output logic [NUM_REQ-1:0]     req_err,
  output logic                   mst_cfg_req,
  output logic                   mst_cmd,
  output logic [AW-1:0]          mst_address,
  output logic [DW-1:0]          mst_wdata,
  input  logic                   mst_waccept,
  input  logic [DW-1:0]          mst_rdatap,
  output logic [REQ_WIDTH-1:0]   grant_id,
  output logic                   busy
);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TO_WID < 1 || $bits(ABORT_DATA) != DW) begin : g_bad_cfg
    $error("cbus_master_arb: unsupported parameter set");
  end

  typedef enum logic [2:0] {IDLE, ISSUE, RESP, RELEASE, GAP} state_e;

  state_e                 state_q, state_d;
  logic [REQ_WIDTH-1:0]   last_q, last_d;
  logic [REQ_WIDTH-1:0]   grant_q, grant_d;
  logic                   mreq_q, mreq_d;
  logic                   mcmd_q, mcmd_d;
  logic [AW-1:0]          maddr_q, maddr_d;
  logic [DW-1:0]          mwdata_q, mwdata_d;
  logic [DW-1:0]          rdata_q, rdata_d;
  logic [NUM_REQ-1:0]     wacc_q, wacc_d;
  logic                   busy_q;

  logic                   found;
  logic [REQ_WIDTH-1:0]   win;
  logic                   win_cmd;
  logic [AW-1:0]          win_addr;
  logic [DW-1:0]          win_wdata;
  logic [NUM_REQ-1:0]     grant_oh;

`ifdef CBUS_ARB_TIMEOUT_EN
  logic [TO_WID-1:0]      cnt_q, cnt_d;
  logic [NUM_REQ-1:0]     err_q, err_d;
`endif

  assign grant_oh = NUM_REQ'(1) << grant_q;

  // Circular scan from last_q+1: pass 0 covers indices above last_q, pass 1 wraps to 0..last_q.
  always_comb begin
    found     = 1'b0;
    win       = '0;
    win_cmd   = 1'b0;
    win_addr  = '0;
    win_wdata = '0;
    for (int unsigned p = 0; p < 2; p++) begin
      for (int unsigned j = 0; j < NUM_REQ; j++) begin
        if (!found && req_cfg_req[j] && ((j > 32'(last_q)) == (p == 0))) begin
          found     = 1'b1;
          win       = REQ_WIDTH'(j);
          win_cmd   = req_cmd[j];
          win_addr  = req_address[j*AW +: AW];
          win_wdata = req_wdata[j*DW +: DW];
        end
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    grant_d  = grant_q;
    mreq_d   = mreq_q;
    mcmd_d   = mcmd_q;
    maddr_d  = maddr_q;
    mwdata_d = mwdata_q;
    rdata_d  = rdata_q;
    wacc_d   = '0;
`ifdef CBUS_ARB_TIMEOUT_EN
    cnt_d    = cnt_q;
    err_d    = '0;
`endif
    unique case (state_q)
      IDLE: begin
        if (found) begin
          grant_d  = win;
          mreq_d   = 1'b1;
          mcmd_d   = win_cmd;
          maddr_d  = win_addr;
          mwdata_d = win_wdata;
          state_d  = ISSUE;
`ifdef CBUS_ARB_TIMEOUT_EN
          cnt_d    = '0;
`endif
        end
      end
      ISSUE: begin
`ifdef CBUS_ARB_TIMEOUT_EN
        cnt_d = cnt_q + 1'b1;
`endif
        // Accept has priority over a same-cycle abandon and over the terminal count.
        if (mst_waccept) begin
          mreq_d = 1'b0;
          if (!mcmd_q) rdata_d = mst_rdatap;
          wacc_d  = grant_oh;
          state_d = RESP;
        end else if (!req_cfg_req[grant_q]) begin
          mreq_d  = 1'b0;
          state_d = GAP;
        end
`ifdef CBUS_ARB_TIMEOUT_EN
        else if (cnt_q == '1) begin
          mreq_d  = 1'b0;
          rdata_d = ABORT_DATA;
          wacc_d  = grant_oh;
          err_d   = grant_oh;
          state_d = RESP;
        end
`endif
      end
      RESP: state_d = RELEASE;
      RELEASE: begin
        if (!req_cfg_req[grant_q]) state_d = GAP;
      end
      GAP: begin
        last_d  = grant_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (sreset) begin
      state_q  <= IDLE;
      last_q   <= REQ_WIDTH'(NUM_REQ - 1);
      grant_q  <= '0;
      mreq_q   <= 1'b0;
      mcmd_q   <= 1'b0;
      maddr_q  <= '0;
      mwdata_q <= '0;
      rdata_q  <= '0;
      wacc_q   <= '0;
      busy_q   <= 1'b0;
`ifdef CBUS_ARB_TIMEOUT_EN
      cnt_q    <= '0;
      err_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      grant_q  <= grant_d;
      mreq_q   <= mreq_d;
      mcmd_q   <= mcmd_d;
      maddr_q  <= maddr_d;
      mwdata_q <= mwdata_d;
      rdata_q  <= rdata_d;
      wacc_q   <= wacc_d;
      busy_q   <= (state_d != IDLE);
`ifdef CBUS_ARB_TIMEOUT_EN
      cnt_q    <= cnt_d;
      err_q    <= err_d;
`endif
    end
  end

  assign req_waccept = wacc_q;
  assign req_rresp   = wacc_q;
  assign req_rdatap  = rdata_q;
`ifdef CBUS_ARB_TIMEOUT_EN
  assign req_err     = err_q;
`else
  assign req_err     = '0;
`endif
  assign mst_cfg_req = mreq_q;
  assign mst_cmd     = mcmd_q;
  assign mst_address = maddr_q;
  assign mst_wdata   = mwdata_q;
  assign grant_id    = grant_q;
  assign busy        = busy_q;

endmodule

// File: doc/cbus_master_arb.md
Name: cbus_master_arb

Overview:
- Round-robin arbiter that shares one cbus slave port between N cbus masters.
- The shared port is typically the near port of a cbus_select_if.
- Latches the winning requester's address, cmd and wdata, then runs one downstream transaction.
- Returns the accept pulse and read data to the winner only.
- Sits between the core-side cbus masters and the unit select logic.

Parameters:
- NUM_REQ, 4, number of requesting masters (2..8).
- REQ_WIDTH, clog2(NUM_REQ), width of the grant index.
- AW, 16, address width.
- DW, 32, data width.
- TO_WID, 8, timeout counter width (used only when CBUS_ARB_TIMEOUT_EN is defined).
- ABORT_DATA, 32'hDEAD_BEEF, read data returned on timeout abort.

Ports:
- clk  in  1  system clock.
- sreset  in  1  synchronous reset, active-high.
- req_cfg_req  in  NUM_REQ  per-requester request; held high until that requester's req_waccept is seen.
- req_cmd  in  NUM_REQ  per-requester command; 1 = write, 0 = read.
- req_address  in  AW*NUM_REQ  packed addresses; requester 0 in the LSBs.
- req_wdata  in  DW*NUM_REQ  packed write data; requester 0 in the LSBs.
- req_waccept  out  NUM_REQ  one-cycle accept pulse to the granted requester.
- req_rresp  out  NUM_REQ  same timing as req_waccept.
- req_rdatap  out  DW  read data; valid while req_rresp is high.
- req_err  out  NUM_REQ  abort flag; pulses with req_waccept. Constant 0 without the macro.
- mst_cfg_req  out  1  downstream request.
- mst_cmd  out  1  downstream command.
- mst_address  out  AW  downstream address.
- mst_wdata  out  DW  downstream write data.
- mst_waccept  in  1  downstream accept (rresp is identical and is not used).
- mst_rdatap  in  DW  downstream read data; valid with mst_waccept.
- grant_id  out  REQ_WIDTH  index of the current or last granted requester.
- busy  out  1  high whenever the FSM is not IDLE.

Behaviour:
- Single clock domain (clk). Reset is synchronous, active-high (sreset).
- All outputs are registered.
- Reset values: every output = 0; FSM = IDLE; last_grant = NUM_REQ-1, so requester 0 wins first.
- FSM states: IDLE, ISSUE, RESP, RELEASE, GAP.
- IDLE:
  - If any req_cfg_req bit is set, pick the first set bit scanning circularly from last_grant+1.
  - Latch that requester's cmd, address and wdata into the mst_* registers.
  - grant_id <= winner; mst_cfg_req <= 1; go to ISSUE.
  - Latency: request at cycle 0 gives mst_cfg_req high at cycle 1.
- ISSUE:
  - mst_* outputs are held stable.
  - On mst_waccept: mst_cfg_req <= 0. For a read (cmd = 0), rdata register <= mst_rdatap; for a write, rdata is unchanged. Pulse req_waccept[g] and req_rresp[g] next cycle; go to RESP.
  - Accept-to-requester latency is 1 cycle.
  - If req_cfg_req[g] drops before accept (abandon): mst_cfg_req <= 0, no pulse, go to GAP.
  - If accept and drop occur in the same cycle, accept wins and the pulse is still issued.
- RESP: req_waccept/req_rresp are high for exactly this cycle, then go to RELEASE.
- RELEASE: wait for req_cfg_req[g] == 0, then go to GAP.
- GAP:
  - One idle cycle; last_grant <= g; go to IDLE.
  - Downstream sees at least 2 cycles with mst_cfg_req low between transactions.
- Fairness: with all requesters active, the grant order is 0, 1, ..., NUM_REQ-1, 0, ...
  - A requester that re-requests in the same cycle it is released waits behind the others.
- Non-granted requesters never see pulses. Their request bits may change freely.
- Downstream rules: mst_waccept outside ISSUE is ignored; mst_rdatap is sampled only on accept.
- sreset mid-transaction:
  - Next cycle the FSM is in IDLE, all outputs = 0, last_grant = NUM_REQ-1.
  - mst_cfg_req drops immediately; no pulse is issued.

Optional Feature:
CBUS_ARB_TIMEOUT_EN
- Defined:
  - A TO_WID-bit counter is cleared on entry to ISSUE and increments every ISSUE cycle.
  - When it reaches all-ones without mst_waccept, the arbiter aborts: mst_cfg_req <= 0, rdata <= ABORT_DATA, go to RESP.
  - In RESP, req_err[g] pulses together with req_waccept[g].
  - mst_waccept in the same cycle as the terminal count wins; no error is flagged.
- Not defined:
  - No counter is built and ISSUE waits indefinitely.
  - req_err is tied to 0.

Test Plan:
- Single read: req 2 reads 16'h0104 → mst_cfg_req at cycle 1; mst_waccept with 32'h1234_5678 at cycle 5 → req_rresp[2] pulse and req_rdatap = 32'h1234_5678 at cycle 6; grant_id = 2.
- All 4 requesting continuously after reset → grants 0, 1, 2, 3, 0. Each req_waccept pulse lasts 1 cycle. mst_cfg_req is low for ≥2 cycles between grants.
- Write: req 1 writes 32'hCAFE_0001 → mst_cmd = 1 and mst_wdata = 32'hCAFE_0001 held stable through ISSUE; req_rdatap keeps its previous value.
- Abandon: req 3 drops cfg_req 2 cycles into ISSUE → mst_cfg_req drops next cycle; no req_waccept; next grant goes to req 0.
- Timeout (macro on, TO_WID = 4): no mst_waccept → abort after 15 ISSUE cycles; req_err[g] = req_waccept[g] = 1; req_rdatap = 32'hDEAD_BEEF. With the macro off, the FSM is still in ISSUE at cycle 100.
- sreset pulse during ISSUE → next cycle busy = 0, mst_cfg_req = 0, no pulse; the next request from req 1 and req 0 together grants req 0.
